// File: rtl/csa_seq_subtractor_if.sv
// ============================================================================
// Module      : csa_seq_subtractor_if
// Description : Operand/result handshake bundle for csa_seq_subtractor.
//               The ovf signal exists only when CSA_SUB_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface csa_seq_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef CSA_SUB_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
`else
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
`endif
endinterface

`default_nettype wire

// File: rtl/csa_seq_subtractor.sv
// ============================================================================
// Module      : csa_seq_subtractor
// Description : Multi-cycle WIDTH-bit subtractor, one 4-bit carry-skip slice
//               per cycle, LSB first. Optional ovf output via CSA_SUB_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_seq_subtractor #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    csa_seq_subtractor_if.slave    bus
);

    localparam int c_nslice = WIDTH / SLICE;
    localparam int c_idx_w  = (c_nslice > 1) ? $clog2(c_nslice) : 1;
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(c_nslice - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    if (SLICE != 4) begin : g_bad_slice
        $error("csa_seq_subtractor: SLICE must be 4");
    end
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("csa_seq_subtractor: WIDTH must be a multiple of 4 and >= 4");
    end

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic [c_idx_w-1:0] r_idx;
    logic               r_carry;
    logic               r_bout;
    logic               w_in_ready;
    logic               w_out_valid;

    logic [WIDTH-1:0]   w_a_sh;
    logic [WIDTH-1:0]   w_b_sh;
    logic [SLICE-1:0]   w_a_k;
    logic [SLICE-1:0]   w_nb_k;
    logic [SLICE-1:0]   w_p_k;
    logic [SLICE-1:0]   w_sum;
    logic [SLICE:0]     w_c;
    logic               w_skip;
    logic               w_cout;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (bus.in_valid)    w_state_nxt = c_calc;
            c_calc:  if (r_idx == c_last) w_state_nxt = c_done;
            c_done:  if (bus.out_ready)   w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // Output logic
    always_comb begin
        w_in_ready  = (r_state == c_idle);
        w_out_valid = (r_state == c_done);
    end

    // Slice under the index is selected by shifting it down to bit 0.
    always_comb begin
        w_a_sh = r_a >> {r_idx, 2'b00};
        w_b_sh = r_b >> {r_idx, 2'b00};
        w_a_k  = w_a_sh[SLICE-1:0];
        w_nb_k = ~w_b_sh[SLICE-1:0];
        w_p_k  = w_a_k ^ w_nb_k;
        w_c    = '0;
        w_c[0] = r_carry;
        for (int i = 0; i < SLICE; i++) begin
            w_sum[i]  = w_p_k[i] ^ w_c[i];
            w_c[i+1]  = (w_a_k[i] & w_nb_k[i]) | (w_p_k[i] & w_c[i]);
        end
        // All-propagate slice: carry-in bypasses the ripple path.
        w_skip = &w_p_k;
        w_cout = w_skip ? r_carry : w_c[SLICE];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_diff  <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_bout  <= 1'b0;
        end else if (r_state == c_idle && bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= ~bus.bin;
            r_idx   <= '0;
        end else if (r_state == c_calc) begin
            for (int k = 0; k < c_nslice; k++) begin
                if (r_idx == c_idx_w'(k)) begin
                    r_diff[k*SLICE +: SLICE] <= w_sum;
                end
            end
            r_carry <= w_cout;
            r_idx   <= r_idx + 1'b1;
            if (r_idx == c_last) begin
                r_bout <= ~w_cout;
            end
        end
    end

`ifdef CSA_SUB_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == c_calc && r_idx == c_last) begin
            r_ovf <= w_c[SLICE-1] ^ w_cout;
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;

endmodule

`default_nettype wire
